// File: rtl/vrf_pkg.sv
// Shared types and constants for the vector register file write-back slice.
package vrf_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned NREG   = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned NBYTES = DATA_W / 8;

  localparam logic [2:0] PPP_ALL   = 3'b000;
  localparam logic [2:0] PPP_UPPER = 3'b001;
  localparam logic [2:0] PPP_LOWER = 3'b010;
  localparam logic [2:0] PPP_EVEN  = 3'b011;
  localparam logic [2:0] PPP_ODD   = 3'b100;

  localparam logic [1:0] WW_B = 2'b00;
  localparam logic [1:0] WW_H = 2'b01;
  localparam logic [1:0] WW_W = 2'b10;
  localparam logic [1:0] WW_D = 2'b11;

  // Write held in the pending register; bit/byte 0 is the MSB end.
  typedef struct packed {
    logic [0:ADDR_W-1] rd;
    logic [0:NBYTES-1] mask;
    logic [0:DATA_W-1] data;
  } wb_req_t;

  // Array word with the pending write's masked bytes overlaid when it targets addr.
  function automatic logic [0:DATA_W-1] bypass(logic [0:DATA_W-1] base, logic vld,
                                               wb_req_t req, logic [0:ADDR_W-1] addr);
    logic [0:DATA_W-1] res;
    res = base;
    for (int j = 0; j < int'(NBYTES); j++) begin
      if (vld && (req.rd == addr) && req.mask[j]) res[8*j +: 8] = req.data[8*j +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/vrf_writeback_if.sv
// ALU-to-writeback write bus plus the two ID-stage read ports.
interface vrf_writeback_if;

  logic                          WB_enable;
  logic [0:vrf_pkg::ADDR_W-1]    ALU_rD;
  logic [0:4]                    ALU_PPPWW;
  logic [0:vrf_pkg::DATA_W-1]    ALU_output;
  logic [0:vrf_pkg::ADDR_W-1]    RF_rA_addr;
  logic [0:vrf_pkg::ADDR_W-1]    RF_rB_addr;
  logic [0:vrf_pkg::DATA_W-1]    RF_rA_data;
  logic [0:vrf_pkg::DATA_W-1]    RF_rB_data;
  logic                          WB_busy;

  modport master (
    output WB_enable, ALU_rD, ALU_PPPWW, ALU_output, RF_rA_addr, RF_rB_addr,
    input  RF_rA_data, RF_rB_data, WB_busy
  );

  modport slave (
    input  WB_enable, ALU_rD, ALU_PPPWW, ALU_output, RF_rA_addr, RF_rB_addr,
    output RF_rA_data, RF_rB_data, WB_busy
  );

endinterface

// File: rtl/pppww_mask_dec.sv
// Decodes the PPPWW field into a per-byte write mask (byte 0 = MSB byte).
module pppww_mask_dec
  import vrf_pkg::*;
(
  input  logic [0:4]        pppww_i,
  output logic [0:NBYTES-1] byte_mask_c
);

  logic [2:0] ppp;
  logic [1:0] ww;
  logic [1:0] sub_shift;
  logic       sub_odd;

  always_comb begin
    ppp         = pppww_i[0:2];
    ww          = pppww_i[3:4];
    sub_odd     = 1'b0;
    byte_mask_c = '0;

    // Subfield size in bytes is 1 << sub_shift.
    case (ww)
      WW_B:    sub_shift = 2'd0;
      WW_H:    sub_shift = 2'd1;
      WW_W:    sub_shift = 2'd2;
      WW_D:    sub_shift = 2'd3;
      default: sub_shift = 2'd3;
    endcase

    for (int j = 0; j < int'(NBYTES); j++) begin
      sub_odd = ((j >> sub_shift) % 2) != 0;
      case (ppp)
        PPP_ALL:   byte_mask_c[j] = 1'b1;
        PPP_UPPER: byte_mask_c[j] = (j < int'(NBYTES / 2));
        PPP_LOWER: byte_mask_c[j] = (j >= int'(NBYTES / 2));
        PPP_EVEN:  byte_mask_c[j] = !sub_odd;
        PPP_ODD:   byte_mask_c[j] = sub_odd;
        default:   byte_mask_c[j] = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/vrf_writeback.sv
// Write-back stage: one-deep pending write in front of a 32x64 register file,
// with two combinational read ports that bypass the pending write.
module vrf_writeback
  import vrf_pkg::*;
(
  input  logic            CLK,
  input  logic            RST,
  vrf_writeback_if.slave  wb
);

  logic [0:NBYTES-1] dec_mask;
  wb_req_t           pend_d, pend_q;
  logic              pend_vld_d, pend_vld_q;
  logic [0:DATA_W-1] rf_q [NREG];

  pppww_mask_dec u_mask_dec (
    .pppww_i     (wb.ALU_PPPWW),
    .byte_mask_c (dec_mask)
  );

  // An all-zero mask is treated as no write at all, so it never shows as busy.
  always_comb begin
    pend_vld_d  = wb.WB_enable && (dec_mask != '0);
    pend_d.rd   = wb.ALU_rD;
    pend_d.mask = dec_mask;
    pend_d.data = wb.ALU_output;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pend_vld_q <= 1'b0;
      pend_q     <= '0;
    end else begin
      pend_vld_q <= pend_vld_d;
      pend_q     <= pend_d;
    end
  end

  // Commit the pending entry one cycle after it was captured.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < int'(NREG); i++) rf_q[i] <= '0;
    end else if (pend_vld_q) begin
      for (int j = 0; j < int'(NBYTES); j++) begin
        if (pend_q.mask[j]) rf_q[pend_q.rd][8*j +: 8] <= pend_q.data[8*j +: 8];
      end
    end
  end

  assign wb.RF_rA_data = bypass(rf_q[wb.RF_rA_addr], pend_vld_q, pend_q, wb.RF_rA_addr);
  assign wb.RF_rB_data = bypass(rf_q[wb.RF_rB_addr], pend_vld_q, pend_q, wb.RF_rB_addr);
  assign wb.WB_busy    = pend_vld_q;

endmodule

// File: tb/tb_vrf_writeback.sv
// Directed and randomized checks of vrf_writeback against hand values and a visible-state model.
module tb_vrf_writeback;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  vrf_writeback_if bus ();

  vrf_writeback dut (
    .CLK (CLK),
    .RST (RST),
    .wb  (bus)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [63:0] vis [32];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [4:0] rd, input logic [4:0] f, input logic [63:0] d);
    bus.WB_enable  = 1'b1;
    bus.ALU_rD     = rd;
    bus.ALU_PPPWW  = f;
    bus.ALU_output = d;
  endtask

  task automatic idle();
    bus.WB_enable = 1'b0;
  endtask

  task automatic rd_addr(input logic [4:0] a, input logic [4:0] b);
    bus.RF_rA_addr = a;
    bus.RF_rB_addr = b;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reference mask: f = {PPP, WW}, returned with index j = byte j (MSB byte first).
  function automatic logic [0:7] tb_mask(input logic [4:0] f);
    logic [0:7] m;
    int size, k;
    size = 1 << f[1:0];
    m = '0;
    for (int j = 0; j < 8; j++) begin
      k = j / size;
      case (f[4:2])
        3'd0: m[j] = 1'b1;
        3'd1: m[j] = (j < 4);
        3'd2: m[j] = (j >= 4);
        3'd3: m[j] = (k % 2 == 0);
        3'd4: m[j] = (k % 2 == 1);
        default: m[j] = 1'b0;
      endcase
    end
    return m;
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                        input logic [0:7] m);
    logic [63:0] r;
    r = old;
    for (int j = 0; j < 8; j++) if (m[j]) r[63-8*j -: 8] = d[63-8*j -: 8];
    return r;
  endfunction

  initial begin
    logic        en;
    logic [4:0]  r_d, f;
    logic [63:0] d;
    logic [0:7]  m;
    logic        exp_busy;

    idle();
    bus.ALU_rD = '0; bus.ALU_PPPWW = '0; bus.ALU_output = '0;
    rd_addr(5'd0, 5'd31);

    // Reset state
    #12;
    chk("reset_rA", bus.RF_rA_data, 64'h0);
    chk("reset_rB", bus.RF_rB_data, 64'h0);
    chk("reset_busy", 64'(bus.WB_busy), 64'h0);
    @(negedge CLK); RST = 1'b1;

    // Reset arriving while a write to R3 is pending
    wr(5'd3, 5'b00011, 64'hFFFF_FFFF_FFFF_FFFF);
    rd_addr(5'd3, 5'd3);
    tick();
    chk("pre_rst_busy", 64'(bus.WB_busy), 64'h1);
    chk("pre_rst_byp", bus.RF_rA_data, 64'hFFFF_FFFF_FFFF_FFFF);
    idle();
    #2 RST = 1'b0;
    #1;
    chk("midrst_rA", bus.RF_rA_data, 64'h0);
    chk("midrst_rB", bus.RF_rB_data, 64'h0);
    chk("midrst_busy", 64'(bus.WB_busy), 64'h0);
    @(negedge CLK); RST = 1'b1;
    tick(); tick();
    chk("r3_after_rst", bus.RF_rA_data, 64'h0);

    // Full 64b write, visible by bypass then from the array
    wr(5'd5, 5'b00011, 64'h0123_4567_89AB_CDEF);
    rd_addr(5'd5, 5'd0);
    tick();
    idle();
    chk("full_byp", bus.RF_rA_data, 64'h0123_4567_89AB_CDEF);
    chk("full_busy", 64'(bus.WB_busy), 64'h1);
    tick();
    chk("full_commit", bus.RF_rA_data, 64'h0123_4567_89AB_CDEF);
    chk("full_idle_busy", 64'(bus.WB_busy), 64'h0);
    tick();
    chk("full_hold", bus.RF_rA_data, 64'h0123_4567_89AB_CDEF);

    // Even 16b subfields cleared over all-ones
    wr(5'd7, 5'b00011, 64'hFFFF_FFFF_FFFF_FFFF);
    rd_addr(5'd7, 5'd7);
    tick();
    wr(5'd7, 5'b01101, 64'h0);
    tick();
    idle();
    chk("even16_byp", bus.RF_rB_data, 64'h0000_FFFF_0000_FFFF);
    tick();
    chk("even16_commit", bus.RF_rA_data, 64'h0000_FFFF_0000_FFFF);

    // Odd bytes, then no-op codes
    wr(5'd2, 5'b00011, 64'h0);
    rd_addr(5'd2, 5'd2);
    tick();
    wr(5'd2, 5'b10000, 64'h1122_3344_5566_7788);
    tick();
    idle();
    tick();
    chk("odd8", bus.RF_rA_data, 64'h0022_0044_0066_0088);
    wr(5'd2, 5'b10100, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    chk("noop101_busy", 64'(bus.WB_busy), 64'h0);
    chk("noop101_data", bus.RF_rA_data, 64'h0022_0044_0066_0088);
    wr(5'd2, 5'b10011, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    idle();
    chk("odd64_busy", 64'(bus.WB_busy), 64'h0);
    tick();
    chk("odd64_data", bus.RF_rB_data, 64'h0022_0044_0066_0088);

    // Back-to-back writes to R9, both ports watching
    rd_addr(5'd9, 5'd9);
    wr(5'd9, 5'b00111, 64'hAAAA_AAAA_AAAA_AAAA);
    tick();
    wr(5'd9, 5'b01011, 64'h5555_5555_5555_5555);
    chk("b2b1_rA", bus.RF_rA_data, 64'hAAAA_AAAA_0000_0000);
    chk("b2b1_rB", bus.RF_rB_data, 64'hAAAA_AAAA_0000_0000);
    tick();
    idle();
    chk("b2b2_rA", bus.RF_rA_data, 64'hAAAA_AAAA_5555_5555);
    chk("b2b2_rB", bus.RF_rB_data, 64'hAAAA_AAAA_5555_5555);
    chk("b2b2_busy", 64'(bus.WB_busy), 64'h1);
    tick();
    chk("b2b_final", bus.RF_rA_data, 64'hAAAA_AAAA_5555_5555);

    // Randomized traffic against the visible-state model
    RST = 1'b0;
    #3;
    for (int i = 0; i < 32; i++) vis[i] = '0;
    @(negedge CLK); RST = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      en  = ($urandom_range(0, 3) != 0);
      r_d = 5'($urandom);
      f   = 5'($urandom);
      d   = {$urandom, $urandom};
      bus.WB_enable = en; bus.ALU_rD = r_d; bus.ALU_PPPWW = f; bus.ALU_output = d;
      tick();
      m = tb_mask(f);
      exp_busy = en && (m != '0);
      if (exp_busy) vis[r_d] = merge(vis[r_d], d, m);
      rd_addr(5'($urandom), (c % 4 == 0) ? r_d : 5'($urandom));
      #1;
      chk("rand_rA", bus.RF_rA_data, vis[bus.RF_rA_addr]);
      chk("rand_rB", bus.RF_rB_data, vis[bus.RF_rB_addr]);
      chk("rand_busy", 64'(bus.WB_busy), 64'(exp_busy));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
